// File: rtl/rf_wb_ctrl_pkg.sv
// Shared constants for the RF write-back controller.
// Register-zero index, requester count and requester indices.
package rf_wb_ctrl_pkg;
  localparam int REG_ZERO = 0;
  localparam int NREQ     = 2;
  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
endpackage

// File: rtl/rf_wb_ctrl_arb.sv
// rr_arb2: two-input round-robin arbiter, combinational.
// Ports: valid[1:0] in, last in (previous winner), grant[1:0] out.
module rr_arb2
  import rf_wb_ctrl_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic            last,
  output logic [NREQ-1:0] grant
);
  always_comb begin
    grant = '0;
    grant[REQ_ALU] = valid[REQ_ALU] & (~valid[REQ_MEM] | last);
    grant[REQ_MEM] = valid[REQ_MEM] & (~valid[REQ_ALU] | ~last);
  end
endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: arbitrates ALU/load writes onto the RF port,
// registers the write, and keeps the per-register busy scoreboard.
// Ports: req_* handshake in, mark/flush/rs* from decode,
// stall/busy to decode, rf_we/rf_wr_address/rf_wr_data to the RF.
module rf_wb_ctrl
  import rf_wb_ctrl_pkg::*;
#(
  parameter int DW  = 8,
  parameter int RFW = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*RFW-1:0] req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  input  logic                mark_valid,
  input  logic [RFW-1:0]      mark_addr,
  input  logic                flush,
  input  logic [RFW-1:0]      rs1_addr,
  input  logic [RFW-1:0]      rs2_addr,
  output logic                stall,
  output logic [2**RFW-1:0]   busy,
  output logic                rf_we,
  output logic [RFW-1:0]      rf_wr_address,
  output logic [DW-1:0]       rf_wr_data
);
  localparam int NR = 2**RFW;

  logic            last_q, last_d;
  logic            we_q, we_d;
  logic [RFW-1:0]  addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [NR-1:0]   busy_q, busy_d;

  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] acc;
  logic            sel;
  logic [RFW-1:0]  sel_addr;
  logic [DW-1:0]   sel_data;

  rr_arb2 u_arb (
    .valid (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  assign req_ready = rst_n ? grant : '0;
  assign acc       = req_valid & req_ready;

  // Grant is one-hot, so the MEM bit alone selects the source.
  assign sel      = acc[REQ_MEM];
  assign sel_addr = req_addr[sel*RFW +: RFW];
  assign sel_data = req_data[sel*DW +: DW];

  always_comb begin
    last_d = last_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (|acc) begin
      last_d = sel;
      we_d   = (sel_addr != RFW'(REG_ZERO));
      addr_d = sel_addr;
      data_d = sel_data;
    end
  end

  // Clear comes from the registered write so stall holds until the
  // RF has committed the data.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NR; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (mark_valid && mark_addr == RFW'(r) && r != REG_ZERO) begin
        busy_d[r] = 1'b1;
      end else if (we_q && addr_q == RFW'(r)) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign stall         = busy_q[rs1_addr] | busy_q[rs2_addr];
  assign busy          = busy_q;
  assign rf_we         = we_q;
  assign rf_wr_address = addr_q;
  assign rf_wr_data    = data_q;
endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Write-back controller for the core's register file: arbitrates the single RF write port between two producers (req 0 = ALU, req 1 = load unit) with round-robin valid/ready handshakes. It registers the winning write onto the RF write port and maintains a per-register busy scoreboard that decode uses to stall on read-after-write hazards. It sits between the execute/memory stages and the register file's `we`/`wr_address`/`wr_data` inputs.

## Interface
- `DW`, 8, data width (matches RF)
- `RFW`, 2, register address width; 2**RFW registers
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  2  per-requester write request
- `req_ready`  out  2  per-requester grant; combinational
- `req_addr`  in  2*RFW  destination registers; requester i uses `[i*RFW +: RFW]`
- `req_data`  in  2*DW  write data; requester i uses `[i*DW +: DW]`
- `mark_valid`  in  1  decode issued an instruction that will write `mark_addr`
- `mark_addr`  in  RFW  destination being marked busy
- `flush`  in  1  clear the whole scoreboard (pipeline squash)
- `rs1_addr`, `rs2_addr`  in  RFW each  decode source registers
- `stall`  out  1  combinational: `busy[rs1_addr] | busy[rs2_addr]`
- `busy`  out  2**RFW  registered scoreboard vector
- `rf_we`  out  1  to RF `we`
- `rf_wr_address`  out  RFW  to RF `wr_address`
- `rf_wr_data`  out  DW  to RF `wr_data`

## Operation
- Reset (`rst_n`=0 at an edge): `rf_we`=0, `rf_wr_address`=0, `rf_wr_data`=0, `busy`=0, round-robin pointer `last`=1, so req 0 wins first. `req_ready`=0 while `rst_n`=0.
- Arbitration: when exactly one requester is valid, it gets ready. When both are valid, the requester not equal to `last` gets ready. Never more than one ready bit is set. Ready is 0 for a non-valid requester.
- Accept = `req_valid[i] & req_ready[i]`. On accept, `last` is set to i, `rf_wr_address`/`rf_wr_data` are loaded from requester i, and `rf_we` is set to `(addr != 0)`.
  - A write to r0 is accepted and discarded; r0 stays zero.
  - With no accept, `rf_we` is set to 0 and address/data hold.
- Requesters hold valid/addr/data stable until accepted. Valid may not depend on ready.
- Scoreboard, next `busy[r]`, in priority order:
  - `flush` → 0 for all r. This overrides marks and clears in the same cycle.
  - `mark_valid & mark_addr==r & r!=0` → 1. A mark wins over a simultaneous clear of the same register.
  - `rf_we & rf_wr_address==r` → 0. The clear is driven by the registered write, not by the accept.
  - otherwise hold.
- `busy[0]` is always 0. Marking an already-busy register leaves it busy; there is no counting. Decode guarantees at most one outstanding producer per register.
- `flush` does not affect arbitration; writes already in flight are still performed.

## Timing
- Request accepted at rising edge k → `rf_we`/addr/data valid from edge k to edge k+1.
- The RF commits at the falling edge between k and k+1.
- The busy bit clears at edge k+1. A decode read after k+1 sees the new value, and `stall` is never released before the data is in the RF.
- Throughput: one write per cycle. Under continuous dual requests, grants alternate 0,1,0,1.
- `req_ready` and `stall` are combinational from inputs and registered state. There is no path from `req_ready` to `req_valid`.
- `mark_valid` at edge k → `busy` set from k; `stall` reflects it in the cycle after k.
- Reset asserted mid-stream drops any pending registered write (`rf_we`=0 after the reset edge). Requesters must re-present.

## Structure
- Shared package/header holds the `REG_ZERO` constant (0), `NREQ`=2, and requester index constants `REQ_ALU`=0 and `REQ_MEM`=1.
- Sub-module `rr_arb2`: a two-input round-robin arbiter (valid[1:0], last, grant[1:0]), purely combinational with the pointer kept in the parent.
- Top-level `rf_wb_ctrl` holds the output register stage, the pointer, and the scoreboard.

## Test plan
- Single write: req 0 with addr 2 and data 0x5A is accepted → `rf_we`=1, addr=2, data=0x5A for one cycle; RF reg 2 reads 0x5A after the following negedge.
- Contention: both valid for 4 cycles with addrs 1 and 3 → grants 0,1,0,1; `rf_we` high for all 4 cycles; each requester gets two writes.
- Write to r0: req 1 with addr 0 and data 0xFF → accepted (`req_ready[1]`=1), `rf_we` stays 0, RF r0 remains 0x00.
- Hazard: mark addr 3, then `rs1_addr`=3 → `stall`=1; req 0 writes r3 → `busy[3]` drops one edge after accept and `stall`=0 afterward.
- Mark/clear collision: registered write to r1 in the same cycle as `mark_valid` with addr 1 → `busy[1]` stays 1. A `flush` in the same cycle as a mark → `busy` equals all zeros.
- Reset: assert `rst_n`=0 while both requesters are valid and `busy`=4'b1110 → `rf_we`=0, `busy`=0, and `req_ready`=0 during reset. After release, req 0 is granted first.
